// File: rtl/axi_lite_slave_mem.sv
// axi_lite_slave_mem
//
// AXI4-Lite responder backed by a word-addressed on-chip memory. The read
// channel (AR/R) and write channel (AW/W/B) are served by two independent
// FSMs, so neither path ever stalls the other. Writes honour byte strobes.
// Accesses outside [BASE_ADDR, BASE_ADDR + DEPTH_WORDS*4) answer SLVERR.
// Out-of-range reads return zero data, and out-of-range writes leave memory
// untouched.
//
// Ports:
//   clk, rst          single rising-edge clock, synchronous active-high reset
//   AR*               read address channel (ARVALID/ARADDR in, ARREADY out)
//   R*                read data channel (RVALID/RDATA/RRESP out, RREADY in)
//   AW*               write address channel (AWVALID/AWADDR in, AWREADY out)
//   W*                write data channel (WVALID/WDATA/WSTRB in, WREADY out)
//   B*                write response channel (BVALID/BRESP out, BREADY in)
// All outputs are registered. Memory contents are not affected by rst.

module axi_lite_slave_mem #(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ARVALID,
    input  logic [31:0] ARADDR,
    output logic        ARREADY,
    output logic        RVALID,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    input  logic        RREADY,
    input  logic        AWVALID,
    input  logic [31:0] AWADDR,
    output logic        AWREADY,
    input  logic        WVALID,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    output logic        WREADY,
    output logic        BVALID,
    output logic [1:0]  BRESP,
    input  logic        BREADY
);

    localparam int          IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN        = 32'(DEPTH_WORDS * 4);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic {R_IDLE, R_DATA}    rd_state_e;
    typedef enum logic {W_COLLECT, W_RESP} wr_state_e;

    // The borrow of a 33-bit subtract gives "addr < BASE_ADDR" without a
    // comparison that degenerates to a constant when BASE_ADDR is zero.
    function automatic logic addr_in_range(input logic [31:0] addr);
        logic [32:0] diff;
        diff = {1'b0, addr} - {1'b0, BASE_ADDR};
        return !diff[32] && (diff[31:0] < SPAN);
    endfunction

    // Word index ignores ADDR[1:0]; only meaningful when addr_in_range().
    function automatic logic [IDX_W-1:0] word_index(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return IDX_W'(off >> 2);
    endfunction

    logic [31:0] mem [DEPTH_WORDS];

    // Read path state
    rd_state_e   rd_state_q, rd_state_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

    // Write path state
    wr_state_e   wr_state_q, wr_state_d;
    logic        aw_held_q, aw_held_d;
    logic        w_held_q, w_held_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;

    logic             commit;
    logic             mem_we;
    logic [IDX_W-1:0] w_idx;

    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;

    // Commit happens on the edge after both halves of the write are held.
    assign commit = (wr_state_q == W_COLLECT) && aw_held_q && w_held_q;
    assign mem_we = commit && addr_in_range(awaddr_q) && !rst;
    assign w_idx  = word_index(awaddr_q);

    // Read FSM next state. The memory is sampled combinationally here, so a
    // write landing on the same edge is not yet visible (read-before-write).
    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ARVALID && arready_q) begin
                    if (addr_in_range(ARADDR)) begin
                        rdata_d = mem[word_index(ARADDR)];
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = 32'h0;
                        rresp_d = RESP_SLVERR;
                    end
                    rvalid_d   = 1'b1;
                    arready_d  = 1'b0;
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && RREADY) begin
                    rvalid_d   = 1'b0;
                    arready_d  = 1'b1;
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Write FSM next state. AW and W are collected independently in either
    // order; each ready drops as soon as its half is held.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        case (wr_state_q)
            W_COLLECT: begin
                if (commit) begin
                    bvalid_d   = 1'b1;
                    bresp_d    = addr_in_range(awaddr_q) ? RESP_OKAY : RESP_SLVERR;
                    awready_d  = 1'b0;
                    wready_d   = 1'b0;
                    wr_state_d = W_RESP;
                end else begin
                    if (AWVALID && awready_q) begin
                        aw_held_d = 1'b1;
                        awaddr_d  = AWADDR;
                    end
                    if (WVALID && wready_q) begin
                        w_held_d = 1'b1;
                        wdata_d  = WDATA;
                        wstrb_d  = WSTRB;
                    end
                    awready_d = !aw_held_d;
                    wready_d  = !w_held_d;
                end
            end
            W_RESP: begin
                awready_d = 1'b0;
                wready_d  = 1'b0;
                if (bvalid_q && BREADY) begin
                    bvalid_d   = 1'b0;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                    wr_state_d = W_COLLECT;
                end
            end
            default: wr_state_d = W_COLLECT;
        endcase
    end

    // Control and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'h0;
            rresp_q    <= RESP_OKAY;
            wr_state_q <= W_COLLECT;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
        end
    end

    // Latched write address/data; qualified by the held flags, so no reset.
    always_ff @(posedge clk) begin
        awaddr_q <= awaddr_d;
        wdata_q  <= wdata_d;
        wstrb_q  <= wstrb_d;
    end

    // Byte-strobed memory write
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) begin
                    mem[w_idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Directed testbench for axi_lite_slave_mem (DEPTH_WORDS=64, BASE=0x1000).
module tb_axi_lite_slave_mem;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] ARADDR, RDATA;
    logic [1:0]  RRESP;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic [31:0] AWADDR, WDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP;

    int n_cmp = 0;
    int n_err = 0;

    axi_lite_slave_mem #(
        .DEPTH_WORDS(64),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ARVALID(ARVALID),
        .ARADDR (ARADDR),
        .ARREADY(ARREADY),
        .RVALID (RVALID),
        .RDATA  (RDATA),
        .RRESP  (RRESP),
        .RREADY (RREADY),
        .AWVALID(AWVALID),
        .AWADDR (AWADDR),
        .AWREADY(AWREADY),
        .WVALID (WVALID),
        .WDATA  (WDATA),
        .WSTRB  (WSTRB),
        .WREADY (WREADY),
        .BVALID (BVALID),
        .BRESP  (BRESP),
        .BREADY (BREADY)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_arready"}, ARREADY, 0);
        chk({pfx, "_awready"}, AWREADY, 0);
        chk({pfx, "_wready"},  WREADY,  0);
        chk({pfx, "_rvalid"},  RVALID,  0);
        chk({pfx, "_bvalid"},  BVALID,  0);
        chk({pfx, "_rdata"},   RDATA,   0);
        chk({pfx, "_rresp"},   RRESP,   0);
        chk({pfx, "_bresp"},   BRESP,   0);
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
        bit   done = 1'b0;
        logic rdy;
        ARVALID = 1'b1;
        ARADDR  = addr;
        RREADY  = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            rdy = ARREADY;
            tick();
            if (rdy) done = 1'b1;
        end
        ARVALID = 1'b0;
        chk("rd_ar_handshake", 32'(done), 1);
        chk("rd_rvalid", RVALID, 1);
        data   = RDATA;
        resp   = RRESP;
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
        logic a, w;
        AWVALID = 1'b1;
        AWADDR  = addr;
        WVALID  = 1'b1;
        WDATA   = data;
        WSTRB   = strb;
        BREADY  = 1'b0;
        for (int k = 0; k < 20 && (AWVALID || WVALID); k++) begin
            a = AWREADY;
            w = WREADY;
            tick();
            if (a) AWVALID = 1'b0;
            if (w) WVALID = 1'b0;
        end
        chk("wr_handshakes_done", 32'(AWVALID | WVALID), 0);
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        for (int k = 0; k < 20 && !BVALID; k++) tick();
        chk("wr_bvalid", BVALID, 1);
        resp   = BRESP;
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;

        rst = 1'b1;
        ARVALID = 0; ARADDR = 0; RREADY = 0;
        AWVALID = 0; AWADDR = 0; WVALID = 0; WDATA = 0; WSTRB = 0; BREADY = 0;
        repeat (3) tick();
        chk_reset("rst");
        rst = 1'b0;
        tick();
        chk("init_arready", ARREADY, 1);
        chk("init_awready", AWREADY, 1);
        chk("init_wready",  WREADY,  1);

        // Test 1: AW and W on the same cycle, full strobe
        AWVALID = 1; AWADDR = BASE + 32'h8;
        WVALID = 1; WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF; BREADY = 0;
        tick();
        AWVALID = 0; WVALID = 0;
        chk("t1_bvalid_n1", BVALID, 0);
        chk("t1_awready_held", AWREADY, 0);
        chk("t1_wready_held", WREADY, 0);
        tick();
        chk("t1_bvalid_n2", BVALID, 1);
        chk("t1_bresp", BRESP, 2'b00);
        BREADY = 1;
        tick();
        BREADY = 0;
        chk("t1_bvalid_clr", BVALID, 0);
        chk("t1_awready_back", AWREADY, 1);
        chk("t1_wready_back", WREADY, 1);
        do_read(BASE + 32'h8, d, r);
        chk("t1_rdata", d, 32'hDEAD_BEEF);
        chk("t1_rresp", r, 2'b00);

        // Test 2: W first, AW three cycles later, partial strobe
        WVALID = 1; WDATA = 32'h1122_3344; WSTRB = 4'b0101;
        tick();
        WVALID = 0;
        chk("t2_wready_e0", WREADY, 0);
        chk("t2_awready_e0", AWREADY, 1);
        tick();
        chk("t2_wready_e1", WREADY, 0);
        tick();
        chk("t2_wready_e2", WREADY, 0);
        AWVALID = 1; AWADDR = BASE + 32'h8;
        tick();
        AWVALID = 0;
        chk("t2_awready_e3", AWREADY, 0);
        chk("t2_wready_e3", WREADY, 0);
        tick();
        chk("t2_bvalid", BVALID, 1);
        chk("t2_bresp", BRESP, 2'b00);
        chk("t2_wready_e4", WREADY, 0);
        BREADY = 1;
        tick();
        BREADY = 0;
        chk("t2_wready_after_b", WREADY, 1);
        do_read(BASE + 32'h8, d, r);
        chk("t2_rdata", d, 32'hDE22_BE44);

        // Test 3: read held off by RREADY=0 for 5 cycles
        ARVALID = 1; ARADDR = BASE + 32'h8; RREADY = 0;
        tick();
        ARVALID = 0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_rvalid_stall", RVALID, 1);
            chk("t3_rdata_stall", RDATA, 32'hDE22_BE44);
            chk("t3_arready_stall", ARREADY, 0);
            tick();
        end
        RREADY = 1;
        tick();
        RREADY = 0;
        chk("t3_rvalid_clr", RVALID, 0);
        chk("t3_arready_back", ARREADY, 1);

        // Test 4: out-of-range accesses
        do_write(BASE, 32'h1234_5678, 4'hF, r);
        chk("t4_word0_bresp", r, 2'b00);
        do_write(BASE + 32'hFC, 32'hA5A5_A5A5, 4'hF, r);
        chk("t4_last_bresp", r, 2'b00);
        do_write(BASE + 32'h100, 32'hFFFF_FFFF, 4'hF, r);
        chk("t4_oor_bresp", r, 2'b10);
        do_read(BASE, d, r);
        chk("t4_word0_intact", d, 32'h1234_5678);
        do_read(BASE + 32'hFC, d, r);
        chk("t4_last_intact", d, 32'hA5A5_A5A5);
        chk("t4_last_rresp", r, 2'b00);
        do_read(BASE - 32'h4, d, r);
        chk("t4_below_rdata", d, 32'h0);
        chk("t4_below_rresp", r, 2'b10);
        do_read(BASE + 32'h100, d, r);
        chk("t4_above_rdata", d, 32'h0);
        chk("t4_above_rresp", r, 2'b10);

        // Test 5: write commit and AR to the same word on the same edge
        do_write(BASE + 32'h10, 32'h0, 4'hF, r);
        AWVALID = 1; AWADDR = BASE + 32'h10;
        WVALID = 1; WDATA = 32'h5; WSTRB = 4'hF; BREADY = 0;
        tick();
        AWVALID = 0; WVALID = 0;
        ARVALID = 1; ARADDR = BASE + 32'h10; RREADY = 0;
        tick();
        ARVALID = 0;
        chk("t5_rvalid", RVALID, 1);
        chk("t5_bvalid", BVALID, 1);
        chk("t5_rdata_old", RDATA, 32'h0);
        RREADY = 1; BREADY = 1;
        tick();
        RREADY = 0; BREADY = 0;
        do_read(BASE + 32'h10, d, r);
        chk("t5_rdata_new", d, 32'h5);

        // Test 6: reset while only AW is held
        do_write(BASE + 32'h14, 32'h7777_7777, 4'hF, r);
        AWVALID = 1; AWADDR = BASE + 32'h14;
        tick();
        AWVALID = 0;
        chk("t6_aw_held", AWREADY, 0);
        rst = 1;
        tick();
        chk_reset("t6_rst");
        rst = 0;
        tick();
        WVALID = 1; WDATA = 32'h0; WSTRB = 4'hF; BREADY = 1;
        tick();
        WVALID = 0;
        for (int i = 0; i < 5; i++) begin
            chk("t6_no_bvalid", BVALID, 0);
            tick();
        end
        BREADY = 0;
        chk("t6_awready_open", AWREADY, 1);
        chk("t6_wready_held", WREADY, 0);
        do_read(BASE + 32'h14, d, r);
        chk("t6_mem_unchanged", d, 32'h7777_7777);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
